// File: rtl/mcu_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_initiator_if
// Description : Request/response channel and decoded memory bus bundle for
//               the MCU bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcu_bus_initiator_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_data_i;
    logic                  slot_i;
    logic                  bus_active_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic                  bus_we_o;
    logic                  bus_wr_strobe_o;
    logic [DATA_WIDTH-1:0] bus_data_o;
    logic [DATA_WIDTH-1:0] bus_data_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_data_o;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, slot_i, bus_data_i,
        output req_ready_o, bus_active_o, bus_addr_o, bus_we_o, bus_wr_strobe_o,
               bus_data_o, resp_valid_o, resp_data_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, slot_i, bus_data_i,
        input  req_ready_o, bus_active_o, bus_addr_o, bus_we_o, bus_wr_strobe_o,
               bus_data_o, resp_valid_o, resp_data_o
    );
endinterface
`default_nettype wire

// File: rtl/mcu_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_initiator
// Description : Single-access bus initiator for the management MCU; waits for
//               a timing-generator slot, drives a fixed-length access, responds.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_bus_initiator #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int STROBE_CYCLES = 3
) (
    input  wire logic           sys_clock_i,
    input  wire logic           reset_i,
    mcu_bus_initiator_if.master mbus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SLOT = 2'd1,
        S_ACCESS    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [3:0] c_strobe_last = 4'(STROBE_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_slot_hit;
    logic                  w_final;

    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_bus_active;
    logic                  r_bus_we;
    logic                  r_bus_strobe;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_data;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = (r_state == S_IDLE) && !reset_i;
        w_accept     = w_req_ready && mbus.req_valid_i;
        w_slot_hit   = (r_state == S_WAIT_SLOT) && mbus.slot_i;
        w_final      = (r_state == S_ACCESS) && (r_cnt == 4'd0);
        case (r_state)
            S_IDLE:      if (w_accept)   w_next_state = S_WAIT_SLOT;
            S_WAIT_SLOT: if (w_slot_hit) w_next_state = S_ACCESS;
            S_ACCESS:    if (w_final)    w_next_state = S_DONE;
            S_DONE:                      w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    // All bus outputs are registered; the strobe is scheduled one edge ahead
    // so it lands exactly on the ACCESS cycle where the counter reads zero.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_bus_active <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_strobe <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_data   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_bus_strobe <= 1'b0;
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_we   <= mbus.req_we_i;
                r_addr <= mbus.req_addr_i;
                r_data <= mbus.req_data_i;
            end
            if (w_slot_hit) begin
                r_cnt        <= c_strobe_last;
                r_bus_active <= 1'b1;
                r_bus_we     <= r_we;
                r_bus_addr   <= r_addr;
                r_bus_data   <= r_data;
                r_bus_strobe <= r_we && (c_strobe_last == 4'd0);
            end else if (r_state == S_ACCESS) begin
                if (w_final) begin
                    r_bus_active <= 1'b0;
                    r_bus_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= r_we ? r_data : mbus.bus_data_i;
                end else begin
                    r_cnt        <= r_cnt - 4'd1;
                    r_bus_strobe <= r_we && (r_cnt == 4'd1);
                end
            end
        end
    end

    assign mbus.req_ready_o     = w_req_ready;
    assign mbus.bus_active_o    = r_bus_active;
    assign mbus.bus_addr_o      = r_bus_addr;
    assign mbus.bus_we_o        = r_bus_we;
    assign mbus.bus_wr_strobe_o = r_bus_strobe;
    assign mbus.bus_data_o      = r_bus_data;
    assign mbus.resp_valid_o    = r_resp_valid;
    assign mbus.resp_data_o     = r_resp_data;

endmodule
`default_nettype wire

// File: doc/mcu_bus_initiator.md
Name: mcu_bus_initiator

Overview:
- Issues single read/write cycles into the 17-bit PET address space on behalf of the management MCU (SPI bridge side).
- Only uses bus slots the timing generator grants while the CPU is off the bus.
- It is the initiator end of the decoded memory bus that address_decoding responds to. Its drive is inserted ahead of the chip-select decode: bit 16 selects the expansion bank, bits 15:0 are the PET map.
- Provides a valid/ready request channel, one-cycle response pulse, and fixed-length strobe timing.

Parameters:
ADDR_WIDTH, 17, request/bus address width (bit 16 = expansion bank A16)
DATA_WIDTH, 8, data width
STROBE_CYCLES, 3, number of sys_clock_i cycles the bus is driven per access (legal range 1..15)

Ports:
sys_clock_i  input  1  system clock, all logic on rising edge
reset_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  initiator can accept a request
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  ADDR_WIDTH  target address
req_data_i  input  DATA_WIDTH  write data
slot_i  input  1  one-cycle pulse from timing generator: MCU bus slot begins (CPU BE low)
bus_active_o  output  1  initiator owns the bus; the address/write mux selects bus_addr_o
bus_addr_o  output  ADDR_WIDTH  address driven to decode/RAM
bus_we_o  output  1  write cycle in progress
bus_wr_strobe_o  output  1  one-cycle write strobe
bus_data_o  output  DATA_WIDTH  write data
bus_data_i  input  DATA_WIDTH  read data from selected RAM/IO
resp_valid_o  output  1  one-cycle completion pulse
resp_data_o  output  DATA_WIDTH  read data (reads) / echoed write data (writes)

Behaviour:
- Interface: one clock (sys_clock_i); reset is synchronous and active-high (reset_i).
- Reset values:
  - req_ready_o=0 during the reset cycle, 1 the cycle after.
  - bus_active_o=0, bus_we_o=0, bus_wr_strobe_o=0, resp_valid_o=0.
  - bus_addr_o=0, bus_data_o=0, resp_data_o=0.
  - State IDLE.
- States: IDLE, WAIT_SLOT, ACCESS, DONE.
- IDLE:
  - req_ready_o=1 (combinational from state; 0 in all other states).
  - On req_valid_i && req_ready_o, latch req_we_i/req_addr_i/req_data_i into internal registers and go to WAIT_SLOT.
- WAIT_SLOT:
  - Waits for slot_i=1. A slot_i asserted in the accept cycle does not count; the earliest usable slot is the cycle after acceptance.
  - On slot_i, go to ACCESS and load counter = STROBE_CYCLES-1.
  - There is no timeout; the initiator waits indefinitely.
- ACCESS:
  - bus_active_o=1, bus_addr_o=latched address, bus_we_o=latched we, bus_data_o=latched data. All are registered and valid from the first ACCESS cycle.
  - The counter decrements each cycle; the final cycle is counter==0.
  - On the final cycle, if write, bus_wr_strobe_o=1 for exactly that cycle.
  - On the final cycle, if read, bus_data_i is sampled into resp_data_o.
  - Then go to DONE.
  - Total ACCESS length is exactly STROBE_CYCLES. With STROBE_CYCLES=1 the strobe/sample occurs in the sole ACCESS cycle.
- DONE:
  - resp_valid_o=1 for exactly one cycle.
  - resp_data_o = sampled read data, or latched write data for writes. It holds until the next completion.
  - bus_active_o=0, bus_we_o=0; bus_addr_o/bus_data_o hold their last values.
  - Returns to IDLE next cycle.
- Latency:
  - Accept to first ACCESS cycle = 1 + (cycles until slot_i).
  - Slot to resp_valid_o = STROBE_CYCLES+1 cycles.
  - Back-to-back throughput is at most one access per slot; a new request is accepted the cycle after DONE.
- Ignored inputs:
  - slot_i is ignored in IDLE, ACCESS and DONE.
  - req_* changes after acceptance have no effect.
- Reset mid-operation: the next edge returns all outputs to reset values. No write strobe is produced, no resp_valid_o is produced, and the pending request is discarded.
- Wrap/width: the counter is 4 bits; addresses pass through unmodified (no increment, no wrap).

Test Plan:
1. Write: reset, request we=1 addr=0x0_8000 data=0xA5, slot_i pulsed 4 cycles later, STROBE_CYCLES=3 -> bus_active_o high 3 cycles with bus_addr_o=0x08000, bus_data_o=0xA5; bus_wr_strobe_o high only on the 3rd; resp_valid_o one cycle later with resp_data_o=0xA5.
2. Read: request we=0 addr=0x1_C000, bus_data_i=0x3C on final ACCESS cycle (other values earlier) -> bus_addr_o=0x1C000, bus_we_o=0, no strobe, resp_data_o=0x3C with resp_valid_o.
3. Slot timing: slot_i high in the same cycle as acceptance and again 2 cycles later -> ACCESS begins only after the second pulse; slot pulses during ACCESS/DONE change nothing.
4. Back-to-back: req_valid_i held high with two requests -> second accepted exactly the cycle after resp_valid_o; req_ready_o low throughout WAIT_SLOT/ACCESS/DONE.
5. Reset mid-operation: assert reset_i in the 2nd ACCESS cycle of a write -> bus_wr_strobe_o never asserts, resp_valid_o never asserts, all outputs at reset values next cycle, req_ready_o=1 the cycle after reset deasserts.
6. STROBE_CYCLES=1 build: write 0x11 to 0x0_0000 -> single ACCESS cycle with bus_active_o and bus_wr_strobe_o both high, resp_valid_o next cycle.
